// File: rtl/lsd_frame_emitter_if.sv
// Segment-descriptor stream: one line segment (two endpoints) per transfer,
// with a marker on the final segment of each frame. Transfer happens on a
// cycle where both s_valid and s_ready are high.
interface lsd_frame_emitter_if #(
  parameter int V_BITW = 9,
  parameter int H_BITW = 10
);
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic [V_BITW-1:0] s_start_v;
  logic [V_BITW-1:0] s_end_v;
  logic [H_BITW-1:0] s_start_h;
  logic [H_BITW-1:0] s_end_h;

  // Producer side drives the descriptor, consumer side returns ready.
  modport master (
    output s_valid, s_last, s_start_v, s_end_v, s_start_h, s_end_h,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_last, s_start_v, s_end_v, s_start_h, s_end_h,
    output s_ready
  );
endinterface

// File: rtl/lsd_frame_emitter.sv
// lsd_frame_emitter: buffers incoming line-segment descriptors in a small FIFO
// and replays them toward a line buffer as framed bursts. A frame opens only
// when the downstream buffer is not write-protected. Once open, a frame always
// runs to its last segment. Each frame is followed by a fixed idle gap, and the
// forwarded and dropped segment counts are reported when that gap ends.
module lsd_frame_emitter #(
  parameter int FRAME_HEIGHT = 480,
  parameter int FRAME_WIDTH  = 640,
  parameter int MAX_LINES    = 4096,
  parameter int FIFO_DEPTH   = 16,
  parameter int GAP_CYCLES   = 4,
  localparam int V_BITW   = $clog2(FRAME_HEIGHT),
  localparam int H_BITW   = $clog2(FRAME_WIDTH),
  localparam int CNT_BITW = $clog2(MAX_LINES) + 1
) (
  input  logic                wclk,
  input  logic                n_rst,
  lsd_frame_emitter_if.slave  s_if,
  input  logic                buf_protect,
  output logic                out_flag,
  output logic                out_valid,
  output logic [V_BITW-1:0]   out_start_v,
  output logic [V_BITW-1:0]   out_end_v,
  output logic [H_BITW-1:0]   out_start_h,
  output logic [H_BITW-1:0]   out_end_h,
  output logic                frame_done,
  output logic [CNT_BITW-1:0] line_count,
  output logic [CNT_BITW-1:0] drop_count
);

  // FIFO geometry: the pointers wrap naturally because the depth is a power of two.
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int OCC_W = AW + 1;
  // Payload layout is {start_v, start_h, end_v, end_h}. A FIFO entry prepends s_last.
  localparam int PW    = 2 * V_BITW + 2 * H_BITW;
  localparam int EW    = PW + 1;
  // The gap counter counts down from GAP_CYCLES-1 to zero.
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_BITW-1:0] MAX_CNT  = CNT_BITW'(MAX_LINES);
  localparam logic [OCC_W-1:0]    FULL_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [GW-1:0]       GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OCC_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_push_data;
  logic [EW-1:0]    w_head;
  logic             w_head_last;
  logic [PW-1:0]    w_head_payload;

  assign w_full  = (r_count == FULL_OCC);
  assign w_empty = (r_count == '0);

  // Ready is held low while reset is applied, so nothing is accepted into a FIFO that is being flushed.
  assign s_if.s_ready = n_rst & ~w_full;
  assign w_push       = s_if.s_valid & s_if.s_ready;

  assign w_push_data = {s_if.s_last, s_if.s_start_v, s_if.s_start_h,
                        s_if.s_end_v, s_if.s_end_h};

  // The head is read asynchronously. It is captured into the output registers on the same edge that pops it.
  assign w_head         = r_mem[r_rd_ptr];
  assign w_head_last    = w_head[EW-1];
  assign w_head_payload = w_head[PW-1:0];

  // FIFO storage write; stale contents are harmless because the pointers define which entries are valid
  always_ff @(posedge wclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the occupancy unchanged
  always_ff @(posedge wclk) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer and output registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_next;

  logic                r_flag;
  logic                r_valid;
  logic [PW-1:0]       r_payload;
  logic [CNT_BITW-1:0] r_fwd_cnt;
  logic [CNT_BITW-1:0] r_drp_cnt;
  logic [GW-1:0]       r_gap_cnt;
  logic                r_done;
  logic [CNT_BITW-1:0] r_line_count;
  logic [CNT_BITW-1:0] r_drop_count;

  logic                w_flag_next;
  logic                w_valid_next;
  logic [PW-1:0]       w_payload_next;
  logic [CNT_BITW-1:0] w_fwd_next;
  logic [CNT_BITW-1:0] w_drp_next;
  logic [GW-1:0]       w_gap_next;
  logic                w_done_next;
  logic [CNT_BITW-1:0] w_line_next;
  logic [CNT_BITW-1:0] w_drop_next;

  // FSM state register
  always_ff @(posedge wclk) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the next values of every registered output and per-frame counter
  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_flag_next    = r_flag;
    w_valid_next   = 1'b0;
    w_payload_next = r_payload;
    w_fwd_next     = r_fwd_cnt;
    w_drp_next     = r_drp_cnt;
    w_gap_next     = r_gap_cnt;
    w_done_next    = 1'b0;
    w_line_next    = r_line_count;
    w_drop_next    = r_drop_count;

    case (r_state)
      ST_IDLE: begin
        // A frame opens only when data is waiting and the buffer is writable.
        if (!w_empty && !buf_protect) begin
          w_state_next = ST_ACTIVE;
          w_flag_next  = 1'b1;
          w_fwd_next   = '0;
          w_drp_next   = '0;
        end
      end

      ST_ACTIVE: begin
        // buf_protect is deliberately ignored here, so an open frame always completes.
        // An empty FIFO is a bubble: the flag stays high and the output is not valid.
        if (!w_empty) begin
          w_pop = 1'b1;
          if (r_fwd_cnt < MAX_CNT) begin
            w_valid_next   = 1'b1;
            w_payload_next = w_head_payload;
            w_fwd_next     = r_fwd_cnt + CNT_BITW'(1);
          end else if (r_drp_cnt != '1) begin
            w_drp_next = r_drp_cnt + CNT_BITW'(1);
          end
          if (w_head_last) begin
            w_state_next = ST_GAP;
            w_gap_next   = GAP_LOAD;
          end
        end
      end

      ST_GAP: begin
        // The flag drops one cycle into the gap, so it still covers the final beat.
        // The low time includes the idle cycle before a following frame, giving exactly GAP_CYCLES low cycles.
        w_flag_next = 1'b0;
        if (r_gap_cnt == '0) begin
          w_state_next = ST_IDLE;
          w_line_next  = r_fwd_cnt;
          w_drop_next  = r_drp_cnt;
          w_done_next  = 1'b1;
        end else begin
          w_gap_next = r_gap_cnt - GW'(1);
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_flag_next  = 1'b0;
      end
    endcase
  end

  // Output and counter registers; reset clears everything, including a frame in progress
  always_ff @(posedge wclk) begin
    if (!n_rst) begin
      r_flag       <= 1'b0;
      r_valid      <= 1'b0;
      r_payload    <= '0;
      r_fwd_cnt    <= '0;
      r_drp_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_done       <= 1'b0;
      r_line_count <= '0;
      r_drop_count <= '0;
    end else begin
      r_flag       <= w_flag_next;
      r_valid      <= w_valid_next;
      r_payload    <= w_payload_next;
      r_fwd_cnt    <= w_fwd_next;
      r_drp_cnt    <= w_drp_next;
      r_gap_cnt    <= w_gap_next;
      r_done       <= w_done_next;
      r_line_count <= w_line_next;
      r_drop_count <= w_drop_next;
    end
  end

  assign out_flag    = r_flag;
  assign out_valid   = r_valid;
  assign out_start_v = r_payload[PW-1 -: V_BITW];
  assign out_start_h = r_payload[PW-V_BITW-1 -: H_BITW];
  assign out_end_v   = r_payload[V_BITW+H_BITW-1 -: V_BITW];
  assign out_end_h   = r_payload[H_BITW-1:0];
  assign frame_done  = r_done;
  assign line_count  = r_line_count;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_lsd_frame_emitter.sv
// Directed bench for lsd_frame_emitter. Two instances share one stimulus:
// "a" uses the default configuration and "b" uses MAX_LINES=4. Segment n is
// encoded as start_v=n+1, start_h=2n+3, end_v=100+n, end_h=500+n.
module tb_lsd_frame_emitter;

  logic wclk = 1'b0;
  logic n_rst;
  logic buf_protect;

  always #5 wclk = ~wclk;

  lsd_frame_emitter_if #(.V_BITW(9), .H_BITW(10)) if_a ();
  lsd_frame_emitter_if #(.V_BITW(9), .H_BITW(10)) if_b ();

  logic        out_flag_a, out_valid_a, frame_done_a;
  logic [8:0]  out_start_v_a, out_end_v_a;
  logic [9:0]  out_start_h_a, out_end_h_a;
  logic [12:0] line_count_a, drop_count_a;

  logic        out_flag_b, out_valid_b, frame_done_b;
  logic [8:0]  out_start_v_b, out_end_v_b;
  logic [9:0]  out_start_h_b, out_end_h_b;
  logic [2:0]  line_count_b, drop_count_b;

  lsd_frame_emitter #(
    .FRAME_HEIGHT(480), .FRAME_WIDTH(640), .MAX_LINES(4096),
    .FIFO_DEPTH(16), .GAP_CYCLES(4)
  ) dut (
    .wclk(wclk), .n_rst(n_rst), .s_if(if_a), .buf_protect(buf_protect),
    .out_flag(out_flag_a), .out_valid(out_valid_a),
    .out_start_v(out_start_v_a), .out_end_v(out_end_v_a),
    .out_start_h(out_start_h_a), .out_end_h(out_end_h_a),
    .frame_done(frame_done_a), .line_count(line_count_a), .drop_count(drop_count_a)
  );

  lsd_frame_emitter #(
    .FRAME_HEIGHT(480), .FRAME_WIDTH(640), .MAX_LINES(4),
    .FIFO_DEPTH(16), .GAP_CYCLES(4)
  ) dut4 (
    .wclk(wclk), .n_rst(n_rst), .s_if(if_b), .buf_protect(buf_protect),
    .out_flag(out_flag_b), .out_valid(out_valid_b),
    .out_start_v(out_start_v_b), .out_end_v(out_end_v_b),
    .out_start_h(out_start_h_b), .out_end_h(out_end_h_b),
    .frame_done(frame_done_b), .line_count(line_count_b), .drop_count(drop_count_b)
  );

  int n_pass;
  int n_fail;
  int n_total;

  // Per-cycle observation counters, updated by clk1
  int         beats_a, beats_b, flag_hi_a, flag_hi_b, done_a;
  int         low_run, gap_seen, last_gap;
  logic       prev_flag, seen_high;
  logic [8:0] q_sv [$];
  logic [9:0] q_eh [$];

  int idx, guard;
  bit stalled;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    beats_a = 0; beats_b = 0; flag_hi_a = 0; flag_hi_b = 0; done_a = 0;
    low_run = 0; gap_seen = 0; last_gap = -1;
    prev_flag = 1'b0; seen_high = 1'b0;
    q_sv.delete(); q_eh.delete();
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic clk1();
    @(posedge wclk);
    #1;
    if (out_flag_a) begin
      flag_hi_a++;
      if (!prev_flag && seen_high) begin
        gap_seen++;
        last_gap = low_run;
      end
      seen_high = 1'b1;
      low_run   = 0;
    end else begin
      low_run++;
    end
    prev_flag = out_flag_a;
    if (out_flag_b) flag_hi_b++;
    if (out_valid_a) begin
      beats_a++;
      q_sv.push_back(out_start_v_a);
      q_eh.push_back(out_end_h_a);
    end
    if (out_valid_b) beats_b++;
    if (frame_done_a) done_a++;
  endtask

  task automatic drive_seg(input logic v, input logic last, input int n);
    if_a.s_valid = v;            if_b.s_valid = v;
    if_a.s_last = last;          if_b.s_last = last;
    if_a.s_start_v = 9'(n + 1);  if_b.s_start_v = 9'(n + 1);
    if_a.s_start_h = 10'(2*n+3); if_b.s_start_h = 10'(2*n+3);
    if_a.s_end_v = 9'(100 + n);  if_b.s_end_v = 9'(100 + n);
    if_a.s_end_h = 10'(500 + n); if_b.s_end_h = 10'(500 + n);
  endtask

  task automatic run_until_done(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (done_a < n && k < budget) begin
      clk1();
      k++;
    end
    chk(tag, 32'(done_a >= n), 1);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    mon_clear();
    n_rst = 1'b0;
    buf_protect = 1'b0;
    drive_seg(1'b0, 1'b0, 0);

    // Reset state
    repeat (3) clk1();
    chk("rst_ready", if_a.s_ready, 0);
    chk("rst_flag", out_flag_a, 0);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_start_v", out_start_v_a, 0);
    chk("rst_done", frame_done_a, 0);
    chk("rst_line", line_count_a, 0);
    chk("rst_drop", drop_count_a, 0);
    n_rst = 1'b1;
    #1;
    chk("rel_ready", if_a.s_ready, 1);

    // Three-segment frame: exact cycle timing
    mon_clear();
    drive_seg(1'b1, 1'b0, 0);
    clk1();
    chk("f3_p0_flag", out_flag_a, 0);
    drive_seg(1'b1, 1'b0, 1);
    clk1();
    chk("f3_p1_flag", out_flag_a, 1);
    chk("f3_p1_valid", out_valid_a, 0);
    drive_seg(1'b1, 1'b1, 2);
    clk1();
    drive_seg(1'b0, 1'b0, 0);
    chk("f3_p2_valid", out_valid_a, 1);
    chk("f3_p2_start_v", out_start_v_a, 1);
    chk("f3_p2_end_h", out_end_h_a, 500);
    clk1();
    chk("f3_p3_valid", out_valid_a, 1);
    chk("f3_p3_start_h", out_start_h_a, 5);
    clk1();
    chk("f3_p4_valid", out_valid_a, 1);
    chk("f3_p4_flag", out_flag_a, 1);
    chk("f3_p4_end_v", out_end_v_a, 102);
    clk1();
    chk("f3_p5_flag", out_flag_a, 0);
    chk("f3_p5_valid", out_valid_a, 0);
    chk("f3_p5_hold_start_v", out_start_v_a, 3);
    clk1();
    clk1();
    chk("f3_p7_done", frame_done_a, 0);
    chk("f3_p7_flag", out_flag_a, 0);
    clk1();
    chk("f3_p8_done", frame_done_a, 1);
    chk("f3_p8_flag", out_flag_a, 0);
    chk("f3_line", line_count_a, 3);
    chk("f3_drop", drop_count_a, 0);
    chk("f3_line_b", line_count_b, 3);
    clk1();
    chk("f3_p9_done", frame_done_a, 0);
    chk("f3_flag_hi", flag_hi_a, 4);

    // buf_protect holds a queued frame back
    mon_clear();
    buf_protect = 1'b1;
    drive_seg(1'b1, 1'b0, 10);
    clk1();
    drive_seg(1'b1, 1'b1, 11);
    clk1();
    drive_seg(1'b0, 1'b0, 0);
    repeat (10) clk1();
    chk("bp_flag_hi", flag_hi_a, 0);
    chk("bp_beats", beats_a, 0);
    chk("bp_ready", if_a.s_ready, 1);
    buf_protect = 1'b0;
    run_until_done(1, 30, "bp_done_timeout");
    chk("bp_beats_after", beats_a, 2);
    chk("bp_line", line_count_a, 2);
    chk("bp_first_sv", (q_sv.size() > 0) ? 32'(q_sv[0]) : 32'hFFFF, 11);
    chk("bp_second_sv", (q_sv.size() > 1) ? 32'(q_sv[1]) : 32'hFFFF, 12);
    clk1();

    // Six segments: instance b forwards 4 and drops 2
    mon_clear();
    for (int i = 0; i < 6; i++) begin
      drive_seg(1'b1, (i == 5), 20 + i);
      clk1();
    end
    drive_seg(1'b0, 1'b0, 0);
    run_until_done(1, 40, "m4_done_timeout");
    chk("m4_beats_b", beats_b, 4);
    chk("m4_beats_a", beats_a, 6);
    chk("m4_line_b", line_count_b, 4);
    chk("m4_drop_b", drop_count_b, 2);
    chk("m4_line_a", line_count_a, 6);
    chk("m4_drop_a", drop_count_a, 0);
    chk("m4_flag_span_b", flag_hi_b, 7);
    chk("m4_hold_sv_b", out_start_v_b, 24);
    chk("m4_hold_sv_a", out_start_v_a, 26);
    clk1();

    // Twenty segments against a 16-deep FIFO while protected
    mon_clear();
    buf_protect = 1'b1;
    idx = 0; guard = 0; stalled = 1'b0;
    while (idx < 20 && guard < 200) begin
      drive_seg(1'b1, (idx == 19), idx);
      if (if_a.s_ready) begin
        clk1();
        idx++;
      end else begin
        if (!stalled) begin
          stalled = 1'b1;
          chk("ff_pushes_at_full", idx, 16);
          chk("ff_ready_b_low", if_b.s_ready, 0);
          repeat (5) clk1();
          chk("ff_flag_while_prot", flag_hi_a, 0);
          buf_protect = 1'b0;
        end else begin
          clk1();
        end
      end
      guard++;
    end
    drive_seg(1'b0, 1'b0, 0);
    buf_protect = 1'b0;
    chk("ff_stalled", stalled, 1);
    chk("ff_all_pushed", idx, 20);
    run_until_done(1, 100, "ff_done_timeout");
    chk("ff_line", line_count_a, 20);
    chk("ff_beats", beats_a, 20);
    chk("ff_line_b", line_count_b, 4);
    chk("ff_drop_b_sat", drop_count_b, 7);
    for (int k = 0; k < 20 && k < q_sv.size(); k++) begin
      chk($sformatf("ff_sv_%0d", k), q_sv[k], 32'(k + 1));
      chk($sformatf("ff_eh_%0d", k), q_eh[k], 32'(500 + k));
    end
    clk1();

    // Back-to-back frames
    mon_clear();
    for (int i = 0; i < 4; i++) begin
      drive_seg(1'b1, (i % 2 == 1), 30 + i);
      clk1();
    end
    drive_seg(1'b0, 1'b0, 0);
    run_until_done(2, 60, "b2b_done_timeout");
    chk("b2b_done_pulses", done_a, 2);
    chk("b2b_gap_seen", gap_seen, 1);
    chk("b2b_gap_len", last_gap, 4);
    chk("b2b_beats", beats_a, 4);
    chk("b2b_line", line_count_a, 2);
    clk1();

    // Reset in the middle of an active frame
    mon_clear();
    drive_seg(1'b1, 1'b0, 40);
    clk1();
    drive_seg(1'b1, 1'b0, 41);
    clk1();
    drive_seg(1'b1, 1'b1, 42);
    clk1();
    drive_seg(1'b0, 1'b0, 0);
    chk("mr_pre_valid", out_valid_a, 1);
    n_rst = 1'b0;
    #1;
    chk("mr_ready_in_rst", if_a.s_ready, 0);
    clk1();
    chk("mr_flag", out_flag_a, 0);
    chk("mr_valid", out_valid_a, 0);
    chk("mr_start_v", out_start_v_a, 0);
    chk("mr_end_h", out_end_h_a, 0);
    chk("mr_line", line_count_a, 0);
    chk("mr_done", frame_done_a, 0);
    chk("mr_flag_b", out_flag_b, 0);
    chk("mr_valid_b", out_valid_b, 0);
    chk("mr_payload_b", {out_start_v_b, out_end_v_b, out_start_h_b, out_end_h_b}, 0);
    chk("mr_line_drop_b", {line_count_b, drop_count_b, frame_done_b}, 0);
    clk1();
    n_rst = 1'b1;
    #1;
    chk("mr_ready_rel", if_a.s_ready, 1);
    mon_clear();
    drive_seg(1'b1, 1'b1, 7);
    clk1();
    drive_seg(1'b0, 1'b0, 0);
    run_until_done(1, 30, "mr_done_timeout");
    chk("mr_post_line", line_count_a, 1);
    chk("mr_post_drop", drop_count_a, 0);
    chk("mr_post_beats", beats_a, 1);
    chk("mr_post_sv", (q_sv.size() > 0) ? 32'(q_sv[0]) : 32'hFFFF, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
